// File: rtl/uart_rcv_if.sv
// Bundles the receiver's line, tick, frame configuration and word-output signals.
interface uart_rcv_if;
  logic       i_active;
  logic       i_rx;
  logic       i_rcv_clk_en;
  logic [1:0] i_frame_type;
  logic [1:0] i_parity_type;
  logic       i_stop_type;
  logic [7:0] o_data;
  logic       o_rcv_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_brk;
  logic       o_busy;

  modport master (
    output i_active, i_rx, i_rcv_clk_en, i_frame_type, i_parity_type, i_stop_type,
    input  o_data, o_rcv_valid, o_parity_err, o_frame_err, o_brk, o_busy
  );

  modport slave (
    input  i_active, i_rx, i_rcv_clk_en, i_frame_type, i_parity_type, i_stop_type,
    output o_data, o_rcv_valid, o_parity_err, o_frame_err, o_brk, o_busy
  );
endinterface

// File: rtl/uart_rcv.sv
// UART receiver: oversampled start detection, centre sampling, 5-8 data bits, parity, 1/2 stops.
// Define UART_RCV_BREAK_EN to enable break detection on o_brk (otherwise tied low).
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | confirming the start bit at its centre
// DATA   | shifting in data bits, LSB first
// PARITY | checking the parity bit
// STOP1  | first stop bit
// STOP2  | second stop bit (two-stop frames only)
module uart_rcv #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  uart_rcv_if.slave  bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_s_d;
  logic [2:0]             r_state;
  logic [CW-1:0]          r_smp;
  logic [3:0]             r_bitcnt;
  logic [7:0]             r_sr;
  logic [1:0]             r_ftype;
  logic [1:0]             r_ptype;
  logic                   r_stype;
  logic                   r_perr;
  logic                   r_ferr;

  logic       w_rx_s;
  logic [3:0] w_fsize;
  logic [7:0] w_word;
  logic       w_start;
  logic       w_sample;
  logic       w_finish;

  assign w_rx_s  = r_sync[SYNC_STAGES-1];
  assign w_fsize = 4'd5 + {2'b00, r_ftype};
  assign w_word  = r_sr >> (4'd8 - w_fsize);
  // Only a high-to-low transition between ticks starts a frame; a line stuck low never does.
  assign w_start = (r_state == S_IDLE) && bus.i_active && bus.i_rcv_clk_en
                   && !w_rx_s && r_rx_s_d;
  assign w_sample = bus.i_active && bus.i_rcv_clk_en && (r_smp == FULL_M1)
                    && (r_state != S_IDLE) && (r_state != S_START);
  assign w_finish = w_sample && (((r_state == S_STOP1) && !r_stype) || (r_state == S_STOP2));
  assign bus.o_busy = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync            <= '1;
      r_rx_s_d          <= 1'b1;
      r_state           <= S_IDLE;
      r_smp             <= '0;
      r_bitcnt          <= '0;
      r_sr              <= '0;
      r_ftype           <= '0;
      r_ptype           <= '0;
      r_stype           <= 1'b0;
      r_perr            <= 1'b0;
      r_ferr            <= 1'b0;
      bus.o_data        <= '0;
      bus.o_rcv_valid   <= 1'b0;
      bus.o_parity_err  <= 1'b0;
      bus.o_frame_err   <= 1'b0;
    end else begin
      r_sync          <= {r_sync[SYNC_STAGES-2:0], bus.i_rx};
      bus.o_rcv_valid <= 1'b0;
      if (bus.i_rcv_clk_en) r_rx_s_d <= w_rx_s;
      if (!bus.i_active) begin
        r_state <= S_IDLE;
      end else if (bus.i_rcv_clk_en) begin
        if (w_start) begin
          r_ftype  <= bus.i_frame_type;
          r_ptype  <= bus.i_parity_type;
          r_stype  <= bus.i_stop_type;
          r_smp    <= '0;
          r_bitcnt <= '0;
          r_ferr   <= 1'b0;
          r_state  <= S_START;
        end else if (r_state == S_START) begin
          if (r_smp == HALF_M1) begin
            r_smp   <= '0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_smp <= r_smp + CW'(1);
          end
        end else if (r_state != S_IDLE) begin
          if (!w_sample) begin
            r_smp <= r_smp + CW'(1);
          end else begin
            r_smp <= '0;
            case (r_state)
              S_DATA: begin
                r_sr <= {w_rx_s, r_sr[7:1]};
                if (r_bitcnt == w_fsize - 4'd1)
                  r_state <= (^r_ptype) ? S_PARITY : S_STOP1;
                else
                  r_bitcnt <= r_bitcnt + 4'd1;
              end
              S_PARITY: begin
                r_perr  <= w_rx_s ^ (^w_word) ^ (r_ptype == 2'b10);
                r_state <= S_STOP1;
              end
              S_STOP1: begin
                r_ferr  <= ~w_rx_s;
                r_state <= r_stype ? S_STOP2 : S_IDLE;
              end
              default: r_state <= S_IDLE;
            endcase
            if (w_finish) begin
              bus.o_data       <= w_word;
              bus.o_parity_err <= (^r_ptype) ? r_perr : 1'b0;
              bus.o_frame_err  <= r_ferr | ~w_rx_s;
              bus.o_rcv_valid  <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef UART_RCV_BREAK_EN
  logic r_all0;

  // Break qualifies on data, parity and STOP1 all low; a second stop bit is not considered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_all0    <= 1'b0;
      bus.o_brk <= 1'b0;
    end else begin
      bus.o_brk <= 1'b0;
      if (w_start)
        r_all0 <= 1'b1;
      else if (w_sample && (r_state != S_STOP2))
        r_all0 <= r_all0 & ~w_rx_s;
      if (w_finish)
        bus.o_brk <= (r_state == S_STOP1) ? (r_all0 & ~w_rx_s) : r_all0;
    end
  end
`else
  assign bus.o_brk = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rcv.sv
// Self-checking bench for uart_rcv: directed frames plus randomized back-to-back traffic.
module tb_uart_rcv;
  localparam int OS = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rcv_if bus ();
  uart_rcv #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  rec_t        q_got[$];
  rec_t        q_exp[$];
  int unsigned t_valid[$];
  int unsigned cyc = 0;
  int unsigned t_start = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          div = 1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rec_t r;
    if (bus.o_rcv_valid === 1'b1) begin
      r = {bus.o_data, bus.o_parity_err, bus.o_frame_err, bus.o_brk};
      q_got.push_back(r);
      t_valid.push_back(cyc);
    end
  end

  task automatic tick_cycle();
    for (int k = 0; k < div; k++) begin
      bus.i_rcv_clk_en = (k == div - 1);
      @(negedge clk);
    end
  endtask

  task automatic send_bit(input logic v);
    bus.i_rx = v;
    repeat (OS) tick_cycle();
  endtask

  task automatic idle(input int n);
    bus.i_rx = 1'b1;
    repeat (n) tick_cycle();
  endtask

  // Reference: what the receiver must report, derived from the bits that were put on the line.
  function automatic rec_t model(input logic [7:0] w, input logic [1:0] ft, input logic [1:0] pt,
                                 input logic st, input logic pbit, input logic s1, input logic s2);
    rec_t m;
    int   fs;
    logic has_par;
    fs      = 5 + int'(ft);
    m.d     = w & 8'((1 << fs) - 1);
    has_par = (pt == 2'b01) || (pt == 2'b10);
    m.pe    = has_par && ((($countones(m.d) + int'(pbit)) % 2) != ((pt == 2'b10) ? 1 : 0));
    m.fe    = !s1 || (st && !s2);
`ifdef UART_RCV_BREAK_EN
    m.bk    = (m.d == 8'h00) && !(has_par && pbit) && !s1;
`else
    m.bk    = 1'b0;
`endif
    return m;
  endfunction

  task automatic send_frame(input logic [7:0] w, input logic [1:0] ft, input logic [1:0] pt,
                            input logic st, input logic flip, input logic s1, input logic s2);
    int   fs;
    logic [7:0] d;
    logic pbit;
    fs = 5 + int'(ft);
    d  = w & 8'((1 << fs) - 1);
    pbit = ((pt == 2'b10) ? ~(^d) : (^d)) ^ flip;
    q_exp.push_back(model(w, ft, pt, st, pbit, s1, s2));
    bus.i_frame_type  = ft;
    bus.i_parity_type = pt;
    bus.i_stop_type   = st;
    t_start = cyc;
    send_bit(1'b0);
    for (int i = 0; i < fs; i++) send_bit(w[i]);
    if (pt == 2'b01 || pt == 2'b10) send_bit(pbit);
    send_bit(s1);
    if (st) send_bit(s2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.o_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", bus.o_data); else pass_cnt++;
    total_cnt++; if (bus.o_rcv_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.o_rcv_valid); else pass_cnt++;
    total_cnt++; if (bus.o_parity_err !== 1'b0) $display("FAIL reset_perr got=%b exp=0", bus.o_parity_err); else pass_cnt++;
    total_cnt++; if (bus.o_frame_err !== 1'b0) $display("FAIL reset_ferr got=%b exp=0", bus.o_frame_err); else pass_cnt++;
    total_cnt++; if (bus.o_brk !== 1'b0) $display("FAIL reset_brk got=%b exp=0", bus.o_brk); else pass_cnt++;
    total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bus.o_busy); else pass_cnt++;
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_8n1();
    rec_t e;
    int unsigned lat;
    q_got.delete(); q_exp.delete(); t_valid.delete();
    send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    e = q_exp[0];
    total_cnt++; if (q_got.size() != 1) $display("FAIL 8n1_count got=%0d exp=1", q_got.size()); else pass_cnt++;
    if (q_got.size() >= 1) begin
      total_cnt++; if (q_got[0].d !== e.d) $display("FAIL 8n1_data got=%h exp=%h", q_got[0].d, e.d); else pass_cnt++;
      total_cnt++; if (q_got[0].pe !== 1'b0 || q_got[0].fe !== 1'b0)
        $display("FAIL 8n1_flags got=%b%b exp=00", q_got[0].pe, q_got[0].fe); else pass_cnt++;
      lat = t_valid[0] - t_start;
      total_cnt++; if (!(lat >= 150 && lat <= 160)) $display("FAIL 8n1_latency got=%0d exp=150..160", lat); else pass_cnt++;
    end
  endtask

  task automatic test_7e2();
    q_got.delete(); q_exp.delete();
    send_frame(8'h5A, 2'b10, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h5A, 2'b10, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(4);
    total_cnt++; if (q_got.size() != 2) $display("FAIL 7e2_count got=%0d exp=2", q_got.size()); else pass_cnt++;
    for (int i = 0; i < 2 && i < q_got.size(); i++) begin
      total_cnt++; if (q_got[i].d !== 8'h5A) $display("FAIL 7e2_data[%0d] got=%h exp=5a", i, q_got[i].d); else pass_cnt++;
      total_cnt++; if (q_got[i].pe !== q_exp[i].pe)
        $display("FAIL 7e2_perr[%0d] got=%b exp=%b", i, q_got[i].pe, q_exp[i].pe); else pass_cnt++;
    end
  endtask

  task automatic test_5o1();
    q_got.delete(); q_exp.delete();
    send_frame(8'hF3, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    total_cnt++; if (q_got.size() != 1) $display("FAIL 5o1_count got=%0d exp=1", q_got.size()); else pass_cnt++;
    if (q_got.size() >= 1) begin
      total_cnt++; if (q_got[0].d !== 8'h13) $display("FAIL 5o1_data got=%h exp=13", q_got[0].d); else pass_cnt++;
      total_cnt++; if (q_got[0].pe !== 1'b0) $display("FAIL 5o1_perr got=%b exp=0", q_got[0].pe); else pass_cnt++;
    end
  endtask

  task automatic test_glitch();
    logic saw_busy;
    q_got.delete();
    saw_busy = 1'b0;
    bus.i_rx = 1'b0;
    repeat (4) begin tick_cycle(); saw_busy |= bus.o_busy; end
    bus.i_rx = 1'b1;
    repeat (8) begin tick_cycle(); saw_busy |= bus.o_busy; end
    total_cnt++; if (saw_busy !== 1'b1) $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); else pass_cnt++;
    total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL glitch_busy_end got=%b exp=0", bus.o_busy); else pass_cnt++;
    idle(200);
    total_cnt++; if (q_got.size() != 0) $display("FAIL glitch_valid got=%0d exp=0", q_got.size()); else pass_cnt++;
  endtask

  task automatic test_break();
    q_got.delete(); q_exp.delete();
    send_frame(8'h00, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.i_rx = 1'b0;
    repeat (300) tick_cycle();
    total_cnt++; if (q_got.size() != 1) $display("FAIL break_count got=%0d exp=1", q_got.size()); else pass_cnt++;
    if (q_got.size() >= 1) begin
      total_cnt++; if (q_got[0].fe !== 1'b1) $display("FAIL break_ferr got=%b exp=1", q_got[0].fe); else pass_cnt++;
      total_cnt++; if (q_got[0].bk !== q_exp[0].bk) $display("FAIL break_brk got=%b exp=%b", q_got[0].bk, q_exp[0].bk); else pass_cnt++;
    end
    idle(2 * OS);
    send_frame(8'h55, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    total_cnt++; if (q_got.size() != 2) $display("FAIL break_recover_count got=%0d exp=2", q_got.size()); else pass_cnt++;
    if (q_got.size() >= 2) begin
      total_cnt++; if (q_got[1] !== q_exp[1]) $display("FAIL break_recover got=%h exp=%h", q_got[1], q_exp[1]); else pass_cnt++;
    end
  endtask

  task automatic partial_frame();
    bus.i_frame_type = 2'b11; bus.i_parity_type = 2'b00; bus.i_stop_type = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
  endtask

  task automatic test_abort();
    q_got.delete(); q_exp.delete();
    send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(8);
    partial_frame();
    bus.i_active = 1'b0;
    bus.i_rx = 1'b1;
    @(negedge clk);
    total_cnt++; if (bus.o_busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", bus.o_busy); else pass_cnt++;
    repeat (200) tick_cycle();
    bus.i_active = 1'b1;
    idle(40);
    total_cnt++; if (q_got.size() != 1) $display("FAIL abort_valid got=%0d exp=1", q_got.size()); else pass_cnt++;
    total_cnt++; if (bus.o_data !== 8'h3C) $display("FAIL abort_held got=%h exp=3c", bus.o_data); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    q_got.delete();
    partial_frame();
    rst = 1'b1;
    bus.i_rx = 1'b1;
    @(negedge clk);
    total_cnt++; if ({bus.o_data, bus.o_rcv_valid, bus.o_parity_err, bus.o_frame_err, bus.o_brk, bus.o_busy} !== 13'h0)
      $display("FAIL rstmid_outputs got=%h/%b%b%b%b%b exp=0", bus.o_data, bus.o_rcv_valid, bus.o_parity_err,
               bus.o_frame_err, bus.o_brk, bus.o_busy); else pass_cnt++;
    rst = 1'b0;
    idle(200);
    total_cnt++; if (q_got.size() != 0) $display("FAIL rstmid_valid got=%0d exp=0", q_got.size()); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    logic [1:0] ft, pt;
    logic st, flip, s1, s2;
    q_got.delete(); q_exp.delete();
    div = $urandom_range(1, 2);
    idle(4);
    for (int n = 0; n < 40; n++) begin
      w = 8'($urandom); ft = 2'($urandom); pt = 2'($urandom); st = 1'($urandom);
      flip = ($urandom % 4 == 0);
      s1 = ($urandom % 6 != 0);
      s2 = ($urandom % 6 != 0);
      send_frame(w, ft, pt, st, flip, s1, s2);
      if ((st ? s2 : s1) == 1'b0) idle(OS);
      else if ($urandom % 3 == 0) idle($urandom_range(1, 20));
    end
    idle(40);
    div = 1;
    total_cnt++; if (q_got.size() != q_exp.size())
      $display("FAIL b2b_count got=%0d exp=%0d", q_got.size(), q_exp.size()); else pass_cnt++;
    for (int i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
      total_cnt++; if (q_got[i] !== q_exp[i])
        $display("FAIL b2b_word[%0d] got=%h/%b%b%b exp=%h/%b%b%b", i, q_got[i].d, q_got[i].pe, q_got[i].fe,
                 q_got[i].bk, q_exp[i].d, q_exp[i].pe, q_exp[i].fe, q_exp[i].bk); else pass_cnt++;
    end
  endtask

  initial begin
    bus.i_active = 1'b1;
    bus.i_rx = 1'b1;
    bus.i_rcv_clk_en = 1'b1;
    bus.i_frame_type = 2'b11;
    bus.i_parity_type = 2'b00;
    bus.i_stop_type = 1'b0;
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_glitch();
    test_break();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
